// File: rtl/router_mport_if.sv
// Bus bundle for router_mport: byte-serial input stream, per-channel output
// handshakes, and status. The router connects to the slave modport.
interface router_mport_if #(
  parameter int NUM_PORTS = 4
);
  logic [7:0]             dut_inp;
  logic                   inp_valid;
  logic [8*NUM_PORTS-1:0] dut_outp;
  logic [NUM_PORTS-1:0]   outp_valid;
  logic [NUM_PORTS-1:0]   outp_ready;
  logic                   busy;
  logic [3:0]             error;
  logic [15:0]            drop_count;

  modport master (
    output dut_inp, inp_valid, outp_ready,
    input  dut_outp, outp_valid, busy, error, drop_count
  );

  modport slave (
    input  dut_inp, inp_valid, outp_ready,
    output dut_outp, outp_valid, busy, error, drop_count
  );
endinterface

// File: rtl/router_mport.sv
// Store-and-forward packet router: buffers one packet, validates it, then
// forwards it on the output channel selected by its destination address.
module router_mport #(
  parameter int NUM_PORTS = 4,
  parameter int MIN_PKT   = 12,
  parameter int MAX_PKT   = 64
) (
  input logic            clk,
  input logic            reset,
  router_mport_if.slave  bus
);

  localparam int          PTR_W   = $clog2(MAX_PKT);
  localparam int          CH_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [15:0] MAX_CNT = 16'(MAX_PKT);
  localparam logic [15:0] MIN_CNT = 16'(MIN_PKT);
  localparam logic [7:0]  NP_DA   = 8'(NUM_PORTS);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK, S_FWD} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [7:0]             r_buf [MAX_PKT];
  logic [15:0]            r_count;
  logic [31:0]            r_sum;
  logic [PTR_W-1:0]       r_ptr;
  logic [CH_W-1:0]        r_ch;
  logic [8*NUM_PORTS-1:0] r_dut_outp;
  logic [NUM_PORTS-1:0]   r_outp_valid;
  logic                   r_busy;
  logic [3:0]             r_error;
  logic [15:0]            r_drop_count;

  logic [31:0]            w_len;
  logic [31:0]            w_crc_fld;
  logic [7:0]             w_da;
  logic [CH_W-1:0]        w_ch;
  logic [3:0]             w_err_code;
  logic                   w_hs;
  logic                   w_last;
  logic [PTR_W-1:0]       w_ptr_inc;

  assign w_len     = {r_buf[5], r_buf[4], r_buf[3], r_buf[2]};
  assign w_crc_fld = {r_buf[9], r_buf[8], r_buf[7], r_buf[6]};
  assign w_da      = r_buf[1];
  assign w_ch      = CH_W'(w_da - 8'd1);
  assign w_hs      = r_outp_valid[r_ch] & bus.outp_ready[r_ch];
  assign w_last    = (16'(r_ptr) == (r_count - 16'd1));
  assign w_ptr_inc = r_ptr + {{(PTR_W-1){1'b0}}, 1'b1};

  // Packet validation, first matching error in priority order wins
  always_comb begin
    w_err_code = 4'd0;
    if (r_count > MAX_CNT) begin
      w_err_code = 4'd4;
    end else if (r_count < MIN_CNT) begin
      w_err_code = 4'd3;
    end else if (w_len != {16'd0, r_count}) begin
      w_err_code = 4'd5;
    end else if (w_crc_fld != r_sum) begin
      w_err_code = 4'd2;
    end else if ((w_da == 8'd0) || (w_da > NP_DA)) begin
      w_err_code = 4'd6;
    end else begin
      w_err_code = 4'd0;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.inp_valid) w_state_nxt = S_RECV;
        else               w_state_nxt = S_IDLE;
      end
      S_RECV: begin
        if (!bus.inp_valid) w_state_nxt = S_CHECK;
        else                w_state_nxt = S_RECV;
      end
      S_CHECK: begin
        if (w_err_code != 4'd0) w_state_nxt = S_IDLE;
        else                    w_state_nxt = S_FWD;
      end
      S_FWD: begin
        if (w_hs && w_last) w_state_nxt = S_IDLE;
        else                w_state_nxt = S_FWD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Packet buffer capture; bytes past MAX_PKT are counted but not stored
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && bus.inp_valid) begin
      r_buf[0] <= bus.dut_inp;
    end else if ((r_state == S_RECV) && bus.inp_valid && (r_count < MAX_CNT)) begin
      r_buf[r_count[PTR_W-1:0]] <= bus.dut_inp;
    end
  end

  // Counters, checksum, forwarding pointer and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count      <= 16'd0;
      r_sum        <= 32'd0;
      r_ptr        <= {PTR_W{1'b0}};
      r_ch         <= {CH_W{1'b0}};
      r_dut_outp   <= {(8*NUM_PORTS){1'b0}};
      r_outp_valid <= {NUM_PORTS{1'b0}};
      r_busy       <= 1'b0;
      r_error      <= 4'd0;
      r_drop_count <= 16'd0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (bus.inp_valid) begin
            r_count <= 16'd1;
            r_sum   <= 32'd0;
            r_error <= 4'd0;
          end
        end
        S_RECV: begin
          if (bus.inp_valid) begin
            if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
            if ((r_count >= 16'd10) && (r_count < MAX_CNT))
              r_sum <= r_sum + {24'd0, bus.dut_inp};
          end
        end
        S_CHECK: begin
          if (w_err_code != 4'd0) begin
            r_error <= w_err_code;
            if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
          end else begin
            r_ptr                              <= {PTR_W{1'b0}};
            r_ch                               <= w_ch;
            r_outp_valid[w_ch]                 <= 1'b1;
            r_dut_outp[{w_ch, 3'b000} +: 8]    <= r_buf[0];
          end
          // A byte arriving while the buffer is owned is a protocol violation
          if (bus.inp_valid) r_error <= 4'd1;
        end
        S_FWD: begin
          if (w_hs) begin
            if (w_last) begin
              r_outp_valid <= {NUM_PORTS{1'b0}};
              r_dut_outp   <= {(8*NUM_PORTS){1'b0}};
            end else begin
              r_ptr                           <= w_ptr_inc;
              r_dut_outp[{r_ch, 3'b000} +: 8] <= r_buf[w_ptr_inc];
            end
          end
          if (bus.inp_valid) r_error <= 4'd1;
        end
        default: begin
          r_outp_valid <= {NUM_PORTS{1'b0}};
        end
      endcase
    end
  end

  assign bus.dut_outp   = r_dut_outp;
  assign bus.outp_valid = r_outp_valid;
  assign bus.busy       = r_busy;
  assign bus.error      = r_error;
  assign bus.drop_count = r_drop_count;

endmodule
